// File: rtl/instr_decode.sv
// Issue-stage RV32I decoder feeding the ALU operand-select/control interface.
// Registers decode results on each fetch handshake, then follows the ALU's
// two-edge latency on branches/jumps so take_branch can be sampled in RESOLVE
// and turned into a one-cycle fetch redirect.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (illegal opcode -> HALT + illegal flag).
// ALU/select encodings below must match the ALU's constant table.
//
// state   | meaning
// RUN     | accepting instructions, one per cycle
// WAIT1   | control-flow issued, ALU registering control; JALR target captured
// WAIT2   | ALU computing take_branch
// RESOLVE | take_branch valid; redirect fetch if taken (jumps always)
// HALT    | illegal opcode trapped, stalled until reset (macro only)
module instr_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic [31:0] instr_pc,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic        rd_we,
    output logic [4:0]  control,
    output logic [1:0]  imm_en,
    output logic [11:0] imm,
    output logic [19:0] imm_U_J,
    output logic [31:0] pc,
    output logic        issue_valid,
    input  logic [31:0] rs1_data,
    input  logic        take_branch,
    output logic        redirect_valid,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic        illegal,
`endif
    output logic [31:0] redirect_pc
);

    localparam logic [4:0] ALU_ADD_I = 5'd0,  ALU_SUB   = 5'd1,  ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3,  ALU_SLTU  = 5'd4,  ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6,  ALU_SRA   = 5'd7,  ALU_OR    = 5'd8;
    localparam logic [4:0] ALU_AND   = 5'd9,  ALU_LUI   = 5'd10, ALU_AUIPC = 5'd11;
    localparam logic [4:0] ALU_BEQ   = 5'd12, ALU_BNE   = 5'd13, ALU_BLT   = 5'd14;
    localparam logic [4:0] ALU_BGE   = 5'd15, ALU_BLT_U = 5'd16, ALU_BGE_U = 5'd17;
    localparam logic [4:0] ALU_JAL_R = 5'd18;
    localparam logic [1:0] ALU_READ_RS2 = 2'd0, ALU_READ_IMM = 2'd1, ALU_READ_IMM_U = 2'd2;

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;
    localparam logic [6:0] OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {S_RUN, S_WAIT1, S_WAIT2, S_RESOLVE, S_HALT} state_t;

    state_t      state, state_nxt;
    logic        ready_arm;
    logic        transfer;
    logic        jump_q, jalr_q, illegal_q;
    logic [31:0] target_q;

    logic [4:0]  d_rs1, d_rs2, d_rd, d_ctrl;
    logic [1:0]  d_sel;
    logic [11:0] d_imm;
    logic        d_we, d_cf, d_jump, d_jalr, d_illegal;
    logic [31:0] d_target, b_off, j_off;
    logic [2:0]  funct3;

    assign transfer = instr_valid && instr_ready;
    assign funct3   = instr[14:12];
    assign b_off    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign j_off    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Decode the presented instruction into the values to register on transfer.
    always_comb begin
        d_rs1     = instr[19:15];
        d_rs2     = 5'd0;
        d_rd      = instr[11:7];
        d_we      = 1'b0;
        d_ctrl    = ALU_ADD_I;
        d_sel     = ALU_READ_IMM;
        d_imm     = instr[31:20];
        d_cf      = 1'b0;
        d_jump    = 1'b0;
        d_jalr    = 1'b0;
        d_illegal = 1'b0;
        d_target  = instr_pc + b_off;
        case (instr[6:0])
            OP_REG: begin
                d_rs2 = instr[24:20];
                d_sel = ALU_READ_RS2;
                d_we  = 1'b1;
                case (funct3)
                    3'b000:  d_ctrl = instr[30] ? ALU_SUB : ALU_ADD_I;
                    3'b001:  d_ctrl = ALU_SLL;
                    3'b010:  d_ctrl = ALU_SLT;
                    3'b011:  d_ctrl = ALU_SLTU;
                    3'b100:  d_ctrl = ALU_XOR;
                    3'b101:  d_ctrl = instr[30] ? ALU_SRA : ALU_SRL;
                    3'b110:  d_ctrl = ALU_OR;
                    default: d_ctrl = ALU_AND;
                endcase
            end
            OP_IMM: begin
                d_we = 1'b1;
                case (funct3)
                    3'b000:  d_ctrl = ALU_ADD_I;
                    3'b001:  d_ctrl = ALU_SLL;
                    3'b010:  d_ctrl = ALU_SLT;
                    3'b011:  d_ctrl = ALU_SLTU;
                    3'b100:  d_ctrl = ALU_XOR;
                    3'b101:  d_ctrl = instr[30] ? ALU_SRA : ALU_SRL;
                    3'b110:  d_ctrl = ALU_OR;
                    default: d_ctrl = ALU_AND;
                endcase
            end
            OP_LOAD:  d_we = 1'b1;
            OP_STORE: begin
                d_rs2 = instr[24:20];
                d_imm = {instr[31:25], instr[11:7]};
            end
            OP_LUI: begin
                d_rs1  = 5'd0;
                d_sel  = ALU_READ_IMM_U;
                d_ctrl = ALU_LUI;
                d_we   = 1'b1;
            end
            OP_AUIPC: begin
                d_rs1  = 5'd0;
                d_sel  = ALU_READ_IMM_U;
                d_ctrl = ALU_AUIPC;
                d_we   = 1'b1;
            end
            OP_BRANCH: begin
                d_rs2 = instr[24:20];
                d_sel = ALU_READ_RS2;
                d_cf  = 1'b1;
                case (funct3)
                    3'b001:  d_ctrl = ALU_BNE;
                    3'b100:  d_ctrl = ALU_BLT;
                    3'b101:  d_ctrl = ALU_BGE;
                    3'b110:  d_ctrl = ALU_BLT_U;
                    3'b111:  d_ctrl = ALU_BGE_U;
                    default: d_ctrl = ALU_BEQ;
                endcase
            end
            OP_JAL: begin
                d_rs1    = 5'd0;
                d_ctrl   = ALU_JAL_R;
                d_we     = (instr[11:7] != 5'd0);
                d_cf     = 1'b1;
                d_jump   = 1'b1;
                d_target = instr_pc + j_off;
            end
            OP_JALR: begin
                d_ctrl = ALU_JAL_R;
                d_we   = (instr[11:7] != 5'd0);
                d_cf   = 1'b1;
                d_jump = 1'b1;
                d_jalr = 1'b1;
            end
            OP_FENCE, OP_SYSTEM: d_we = 1'b0;
            default: begin
                d_illegal = 1'b1;
                d_rs1     = 5'd0;
                d_rd      = 5'd0;
                d_imm     = 12'd0;
            end
        endcase
    end

    // State register; ready_arm keeps instr_ready low until the first edge after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_RUN;
            ready_arm <= 1'b0;
        end else begin
            state     <= state_nxt;
            ready_arm <= 1'b1;
        end
    end

    // Next-state: control flow walks the fixed ALU latency back to RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (transfer) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                    if (d_illegal)   state_nxt = S_HALT;
                    else if (d_cf)   state_nxt = S_WAIT1;
`else
                    if (d_cf)        state_nxt = S_WAIT1;
`endif
                end
            end
            S_WAIT1:   state_nxt = S_WAIT2;
            S_WAIT2:   state_nxt = S_RESOLVE;
            S_RESOLVE: state_nxt = S_RUN;
            default:   state_nxt = state;
        endcase
    end

    // Outputs: take_branch only matters in RESOLVE; jumps redirect unconditionally.
    always_comb begin
        instr_ready    = ready_arm && (state == S_RUN);
        redirect_valid = (state == S_RESOLVE) && (take_branch || jump_q);
        redirect_pc    = target_q;
    end

    // Decode output registers, loaded on each accepted instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs1_addr    <= 5'd0;
            rs2_addr    <= 5'd0;
            rd_addr     <= 5'd0;
            rd_we       <= 1'b0;
            control     <= ALU_ADD_I;
            imm_en      <= ALU_READ_IMM;
            imm         <= 12'd0;
            imm_U_J     <= 20'd0;
            pc          <= 32'd0;
            issue_valid <= 1'b0;
            jump_q      <= 1'b0;
            jalr_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            issue_valid <= transfer;
            if (transfer) begin
                rs1_addr  <= d_rs1;
                rs2_addr  <= d_rs2;
                rd_addr   <= d_rd;
                rd_we     <= d_we;
                control   <= d_ctrl;
                imm_en    <= d_sel;
                imm       <= d_imm;
                imm_U_J   <= instr[31:12];
                pc        <= instr_pc;
                jump_q    <= d_jump;
                jalr_q    <= d_jalr;
                illegal_q <= d_illegal;
            end
        end
    end

    // Redirect target: PC-relative at decode, JALR rebased on rs1_data during WAIT1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            target_q <= 32'd0;
        end else if (transfer) begin
            target_q <= d_target;
        end else if (state == S_WAIT1 && jalr_q) begin
            target_q <= (rs1_data + {{20{imm[11]}}, imm}) & ~32'd1;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign illegal = illegal_q;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_instr_decode.sv
// Directed-vector bench for instr_decode: decode fields, control-flow
// redirect timing, take_branch filtering, illegal handling and mid-wait reset.
module tb_instr_decode;

    localparam logic [4:0] ALU_ADD_I = 5'd0, ALU_SUB = 5'd1, ALU_LUI = 5'd10, ALU_AUIPC = 5'd11;
    localparam logic [4:0] ALU_BEQ = 5'd12, ALU_JAL_R = 5'd18;
    localparam logic [1:0] ALU_READ_RS2 = 2'd0, ALU_READ_IMM = 2'd1, ALU_READ_IMM_U = 2'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = 32'd0;
    logic [31:0] instr_pc = 32'd0;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        rd_we;
    logic [4:0]  control;
    logic [1:0]  imm_en;
    logic [11:0] imm;
    logic [19:0] imm_U_J;
    logic [31:0] pc;
    logic        issue_valid;
    logic [31:0] rs1_data = 32'd0;
    logic        take_branch = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_decode dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_addr(rd_addr), .rd_we(rd_we), .control(control), .imm_en(imm_en), .imm(imm),
        .imm_U_J(imm_U_J), .pc(pc), .issue_valid(issue_valid), .rs1_data(rs1_data),
        .take_branch(take_branch), .redirect_valid(redirect_valid),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .illegal(illegal),
`endif
        .redirect_pc(redirect_pc)
    );

    // Present one instruction for one edge; returns #1 after that edge.
    task automatic send(input logic [31:0] w, input logic [31:0] a);
        @(negedge clk);
        instr_valid = 1'b1;
        instr = w;
        instr_pc = a;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        n_vec++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %0b want 0", instr_ready); end
        n_vec++; if (control !== ALU_ADD_I) begin n_err++; $display("FAIL rst_control got %0d want %0d", control, ALU_ADD_I); end
        n_vec++; if (imm_en !== ALU_READ_IMM) begin n_err++; $display("FAIL rst_imm_en got %0d want %0d", imm_en, ALU_READ_IMM); end
        n_vec++; if ({rd_we, issue_valid, redirect_valid} !== 3'b000) begin n_err++; $display("FAIL rst_flags got %b want 000", {rd_we, issue_valid, redirect_valid}); end
        n_vec++; if ({pc, redirect_pc, imm, imm_U_J} !== 96'd0) begin n_err++; $display("FAIL rst_values got %h want 0", {pc, redirect_pc, imm, imm_U_J}); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_vec++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_pre_edge got %0b want 0", instr_ready); end
        step();
        n_vec++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_post_edge got %0b want 1", instr_ready); end
    endtask

    task automatic test_alu_ops();
        send(32'h00510093, 32'h40);   // addi x1,x2,5
        n_vec++; if (issue_valid !== 1'b1) begin n_err++; $display("FAIL addi_issue got %0b want 1", issue_valid); end
        n_vec++; if ({rs1_addr, rs2_addr, rd_addr} !== {5'd2, 5'd0, 5'd1}) begin n_err++; $display("FAIL addi_regs got %h want %h", {rs1_addr, rs2_addr, rd_addr}, {5'd2, 5'd0, 5'd1}); end
        n_vec++; if ({imm, imm_en, control, rd_we} !== {12'h005, ALU_READ_IMM, ALU_ADD_I, 1'b1}) begin n_err++; $display("FAIL addi_ctl got %h want %h", {imm, imm_en, control, rd_we}, {12'h005, ALU_READ_IMM, ALU_ADD_I, 1'b1}); end
        n_vec++; if (pc !== 32'h40) begin n_err++; $display("FAIL addi_pc got %h want 40", pc); end
        step();
        n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL idle_issue got %0b want 0", issue_valid); end
        n_vec++; if (rd_addr !== 5'd1) begin n_err++; $display("FAIL idle_hold got %0d want 1", rd_addr); end

        send(32'h123452B7, 32'h44);   // lui x5,0x12345
        n_vec++; if (imm_U_J !== 20'h12345) begin n_err++; $display("FAIL lui_immu got %h want 12345", imm_U_J); end
        n_vec++; if ({imm_en, control, rd_addr, rs1_addr, rs2_addr} !== {ALU_READ_IMM_U, ALU_LUI, 5'd5, 5'd0, 5'd0}) begin n_err++; $display("FAIL lui_ctl got %h want %h", {imm_en, control, rd_addr, rs1_addr, rs2_addr}, {ALU_READ_IMM_U, ALU_LUI, 5'd5, 5'd0, 5'd0}); end

        send(32'h402081B3, 32'h48);   // sub x3,x1,x2
        n_vec++; if ({rs1_addr, rs2_addr, rd_addr, imm_en, control, rd_we} !== {5'd1, 5'd2, 5'd3, ALU_READ_RS2, ALU_SUB, 1'b1}) begin n_err++; $display("FAIL sub_ctl got %h want %h", {rs1_addr, rs2_addr, rd_addr, imm_en, control, rd_we}, {5'd1, 5'd2, 5'd3, ALU_READ_RS2, ALU_SUB, 1'b1}); end

        send(32'h0020A423, 32'h4C);   // sw x2,8(x1)
        n_vec++; if ({rs1_addr, rs2_addr, imm, imm_en, rd_we} !== {5'd1, 5'd2, 12'h008, ALU_READ_IMM, 1'b0}) begin n_err++; $display("FAIL sw_ctl got %h want %h", {rs1_addr, rs2_addr, imm, imm_en, rd_we}, {5'd1, 5'd2, 12'h008, ALU_READ_IMM, 1'b0}); end
    endtask

    task automatic test_branch(input logic taken);
        send(32'h00208463, 32'h100);  // beq x1,x2,+8
        n_vec++; if ({instr_ready, issue_valid, control, imm_en, rd_we} !== {1'b0, 1'b1, ALU_BEQ, ALU_READ_RS2, 1'b0}) begin n_err++; $display("FAIL beq_decode got %h want %h", {instr_ready, issue_valid, control, imm_en, rd_we}, {1'b0, 1'b1, ALU_BEQ, ALU_READ_RS2, 1'b0}); end
        take_branch = taken;
        step();
        n_vec++; if ({instr_ready, redirect_valid} !== 2'b00) begin n_err++; $display("FAIL beq_wait2 got %b want 00", {instr_ready, redirect_valid}); end
        step();
        n_vec++; if ({instr_ready, redirect_valid} !== {1'b0, taken}) begin n_err++; $display("FAIL beq_resolve taken=%0b got %b want %b", taken, {instr_ready, redirect_valid}, {1'b0, taken}); end
        if (taken) begin
            n_vec++; if (redirect_pc !== 32'h108) begin n_err++; $display("FAIL beq_target got %h want 108", redirect_pc); end
        end
        step();
        n_vec++; if ({instr_ready, redirect_valid} !== 2'b10) begin n_err++; $display("FAIL beq_return got %b want 10", {instr_ready, redirect_valid}); end
        take_branch = 1'b0;
    endtask

    task automatic test_jumps();
        send(32'h010000EF, 32'h200);  // jal x1,+16
        n_vec++; if ({control, rd_we, rs1_addr, rs2_addr} !== {ALU_JAL_R, 1'b1, 5'd0, 5'd0}) begin n_err++; $display("FAIL jal_decode got %h want %h", {control, rd_we, rs1_addr, rs2_addr}, {ALU_JAL_R, 1'b1, 5'd0, 5'd0}); end
        step(); step();
        n_vec++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'h210}) begin n_err++; $display("FAIL jal_redirect got %h want %h", {redirect_valid, redirect_pc}, {1'b1, 32'h210}); end
        step();

        send(32'hFFDFF06F, 32'h0);    // jal x0,-4 from pc 0 wraps
        n_vec++; if (rd_we !== 1'b0) begin n_err++; $display("FAIL jal_x0_we got %0b want 0", rd_we); end
        step(); step();
        n_vec++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'hFFFFFFFC}) begin n_err++; $display("FAIL jal_wrap got %h want %h", {redirect_valid, redirect_pc}, {1'b1, 32'hFFFFFFFC}); end
        step();

        rs1_data = 32'h1000;
        send(32'h003280E7, 32'h300);  // jalr x1,3(x5)
        n_vec++; if ({control, imm, imm_en, rs1_addr} !== {ALU_JAL_R, 12'h003, ALU_READ_IMM, 5'd5}) begin n_err++; $display("FAIL jalr_decode got %h want %h", {control, imm, imm_en, rs1_addr}, {ALU_JAL_R, 12'h003, ALU_READ_IMM, 5'd5}); end
        step(); step();
        n_vec++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'h1002}) begin n_err++; $display("FAIL jalr_redirect got %h want %h", {redirect_valid, redirect_pc}, {1'b1, 32'h1002}); end
        step();
        rs1_data = 32'd0;
    endtask

    task automatic test_back_to_back();
        take_branch = 1'b1;
        @(negedge clk);
        instr_valid = 1'b1;
        instr = 32'h00001197;         // auipc x3,0x1
        instr_pc = 32'h400;
        @(posedge clk);
        #1;
        instr = 32'h00510093;         // addi x1,x2,5
        instr_pc = 32'h404;
        n_vec++; if ({issue_valid, instr_ready, control, imm_en, imm_U_J, redirect_valid} !== {1'b1, 1'b1, ALU_AUIPC, ALU_READ_IMM_U, 20'h00001, 1'b0}) begin n_err++; $display("FAIL auipc_issue got %h want %h", {issue_valid, instr_ready, control, imm_en, imm_U_J, redirect_valid}, {1'b1, 1'b1, ALU_AUIPC, ALU_READ_IMM_U, 20'h00001, 1'b0}); end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        n_vec++; if ({issue_valid, control, pc, redirect_valid} !== {1'b1, ALU_ADD_I, 32'h404, 1'b0}) begin n_err++; $display("FAIL b2b_addi got %h want %h", {issue_valid, control, pc, redirect_valid}, {1'b1, ALU_ADD_I, 32'h404, 1'b0}); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL auipc_no_redirect cyc %0d got 1 want 0", i); end
        end
        take_branch = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        send(32'h010000EF, 32'h500);
        step();                        // now in WAIT2
        #2;
        reset = 1'b0;
        #1;
        n_vec++; if ({instr_ready, issue_valid, redirect_valid, rd_we} !== 4'b0000) begin n_err++; $display("FAIL midrst_flags got %b want 0000", {instr_ready, issue_valid, redirect_valid, rd_we}); end
        n_vec++; if ({control, imm_en, pc, redirect_pc, rd_addr} !== {ALU_ADD_I, ALU_READ_IMM, 64'd0, 5'd0}) begin n_err++; $display("FAIL midrst_values got %h want %h", {control, imm_en, pc, redirect_pc, rd_addr}, {ALU_ADD_I, ALU_READ_IMM, 64'd0, 5'd0}); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++; if ({instr_ready, redirect_valid} !== 2'b10) begin n_err++; $display("FAIL midrst_after cyc %0d got %b want 10", i, {instr_ready, redirect_valid}); end
        end
    endtask

    task automatic test_illegal();
        send(32'hFFFFFFFF, 32'h600);
`ifdef DECODE_ILLEGAL_TRAP_EN
        n_vec++; if ({illegal, instr_ready, rd_we} !== 3'b100) begin n_err++; $display("FAIL illegal_trap got %b want 100", {illegal, instr_ready, rd_we}); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if ({illegal, instr_ready} !== 2'b10) begin n_err++; $display("FAIL illegal_halt cyc %0d got %b want 10", i, {illegal, instr_ready}); end
        end
`else
        n_vec++; if ({issue_valid, instr_ready, control, imm_en, imm, rd_addr, rd_we} !== {1'b1, 1'b1, ALU_ADD_I, ALU_READ_IMM, 12'd0, 5'd0, 1'b0}) begin n_err++; $display("FAIL illegal_nop got %h want %h", {issue_valid, instr_ready, control, imm_en, imm, rd_addr, rd_we}, {1'b1, 1'b1, ALU_ADD_I, ALU_READ_IMM, 12'd0, 5'd0, 1'b0}); end
        send(32'h00510093, 32'h604);
        n_vec++; if ({issue_valid, rd_addr, rd_we} !== {1'b1, 5'd1, 1'b1}) begin n_err++; $display("FAIL illegal_next got %h want %h", {issue_valid, rd_addr, rd_we}, {1'b1, 5'd1, 1'b1}); end
`endif
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_branch(1'b1);
        test_branch(1'b0);
        test_jumps();
        test_back_to_back();
        test_reset_mid_wait();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
